// File: rtl/jtag_tap_top.sv
// IEEE 1149.1 TAP controller: 16-state FSM, 4-bit IR, bypass/IDCODE DRs, external chain routing.
// Define TAP_IDCODE_EN to include the IDCODE instruction and its 32-bit register.
module jtag_tap_top #(
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
    input  logic tck_pad_i,
    input  logic trst_pad_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o,
    output logic tdo_padoe_o,
    output logic tdo_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic extest_select_o,
    output logic sample_preload_select_o,
    output logic mbist_select_o,
    output logic debug_select_o,
    input  logic bs_chain_tdi_i,
    input  logic debug_tdi_i,
    input  logic mbist_tdi_i
);
    typedef enum logic [3:0] {
        StTestLogicReset, StRunTestIdle,
        StSelectDr, StCaptureDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdateDr,
        StSelectIr, StCaptureIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdateIr
    } tap_state_e;

    localparam logic [3:0] InstrExtest = 4'b0000;
    localparam logic [3:0] InstrSample = 4'b0001;
    localparam logic [3:0] InstrDebug  = 4'b1000;
    localparam logic [3:0] InstrMbist  = 4'b1001;
    localparam logic [3:0] InstrBypass = 4'b1111;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] InstrIdcode = 4'b0010;
    localparam logic [3:0] InstrReset  = InstrIdcode;
`else
    localparam logic [3:0] InstrReset  = InstrBypass;
`endif

    tap_state_e r_state;
    logic [3:0] r_ir_sr;
    logic [3:0] r_instr;
    logic       r_bypass;
    logic       r_tdo;
    logic       r_tdo_oe;
    logic       w_sel_extest, w_sel_sample, w_sel_debug, w_sel_mbist, w_sel_idcode;
    logic       w_idcode_lsb;
    logic       w_tdo_next;

    always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
        if (trst_pad_i) begin
            r_state <= StTestLogicReset;
        end else begin
            unique case (r_state)
                StTestLogicReset: r_state <= tms_pad_i ? StTestLogicReset : StRunTestIdle;
                StRunTestIdle:    r_state <= tms_pad_i ? StSelectDr : StRunTestIdle;
                StSelectDr:       r_state <= tms_pad_i ? StSelectIr : StCaptureDr;
                StCaptureDr:      r_state <= tms_pad_i ? StExit1Dr : StShiftDr;
                StShiftDr:        r_state <= tms_pad_i ? StExit1Dr : StShiftDr;
                StExit1Dr:        r_state <= tms_pad_i ? StUpdateDr : StPauseDr;
                StPauseDr:        r_state <= tms_pad_i ? StExit2Dr : StPauseDr;
                StExit2Dr:        r_state <= tms_pad_i ? StUpdateDr : StShiftDr;
                StUpdateDr:       r_state <= tms_pad_i ? StSelectDr : StRunTestIdle;
                StSelectIr:       r_state <= tms_pad_i ? StTestLogicReset : StCaptureIr;
                StCaptureIr:      r_state <= tms_pad_i ? StExit1Ir : StShiftIr;
                StShiftIr:        r_state <= tms_pad_i ? StExit1Ir : StShiftIr;
                StExit1Ir:        r_state <= tms_pad_i ? StUpdateIr : StPauseIr;
                StPauseIr:        r_state <= tms_pad_i ? StExit2Ir : StPauseIr;
                StExit2Ir:        r_state <= tms_pad_i ? StUpdateIr : StShiftIr;
                StUpdateIr:       r_state <= tms_pad_i ? StSelectDr : StRunTestIdle;
            endcase
        end
    end

    // The active instruction only changes on Update-IR, so an aborted shift never leaks into it.
    always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
        if (trst_pad_i) begin
            r_ir_sr  <= 4'b0000;
            r_instr  <= InstrReset;
            r_bypass <= 1'b0;
        end else begin
            if (r_state == StCaptureIr) begin
                r_ir_sr <= 4'b0101;
            end else if (r_state == StShiftIr) begin
                r_ir_sr <= {tdi_pad_i, r_ir_sr[3:1]};
            end
            if (r_state == StTestLogicReset) begin
                r_instr <= InstrReset;
            end else if (r_state == StUpdateIr) begin
                r_instr <= r_ir_sr;
            end
            if (r_state == StCaptureDr) begin
                r_bypass <= 1'b0;
            end else if (r_state == StShiftDr) begin
                r_bypass <= tdi_pad_i;
            end
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] r_idcode;

    always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
        if (trst_pad_i) begin
            r_idcode <= IDCODE_VALUE;
        end else if (w_sel_idcode && r_state == StCaptureDr) begin
            r_idcode <= IDCODE_VALUE;
        end else if (w_sel_idcode && r_state == StShiftDr) begin
            r_idcode <= {tdi_pad_i, r_idcode[31:1]};
        end
    end

    assign w_sel_idcode = (r_instr == InstrIdcode);
    assign w_idcode_lsb = r_idcode[0];
`else
    // IDCODE_VALUE has no consumer when the IDCODE register is left out.
    logic w_unused_idcode;
    assign w_unused_idcode = ^IDCODE_VALUE;
    assign w_sel_idcode    = 1'b0;
    assign w_idcode_lsb    = 1'b0;
`endif

    assign w_sel_extest = (r_instr == InstrExtest);
    assign w_sel_sample = (r_instr == InstrSample);
    assign w_sel_debug  = (r_instr == InstrDebug);
    assign w_sel_mbist  = (r_instr == InstrMbist);

    always_comb begin
        w_tdo_next = r_bypass;
        if (r_state == StShiftIr) begin
            w_tdo_next = r_ir_sr[0];
        end else if (w_sel_idcode) begin
            w_tdo_next = w_idcode_lsb;
        end else if (w_sel_extest || w_sel_sample) begin
            w_tdo_next = bs_chain_tdi_i;
        end else if (w_sel_debug) begin
            w_tdo_next = debug_tdi_i;
        end else if (w_sel_mbist) begin
            w_tdo_next = mbist_tdi_i;
        end
    end

    // TDO changes on the falling edge so the far end can sample it on the next rising edge.
    always_ff @(negedge tck_pad_i or posedge trst_pad_i) begin
        if (trst_pad_i) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_next;
            r_tdo_oe <= (r_state == StShiftIr) || (r_state == StShiftDr);
        end
    end

    assign tdo_pad_o               = r_tdo;
    assign tdo_padoe_o             = r_tdo_oe;
    assign tdo_o                   = tdi_pad_i;
    assign shift_dr_o              = (r_state == StShiftDr);
    assign pause_dr_o              = (r_state == StPauseDr);
    assign update_dr_o             = (r_state == StUpdateDr);
    assign capture_dr_o            = (r_state == StCaptureDr);
    assign extest_select_o         = w_sel_extest;
    assign sample_preload_select_o = w_sel_sample;
    assign debug_select_o          = w_sel_debug;
    assign mbist_select_o          = w_sel_mbist;

endmodule

// File: tb/tb_jtag_tap_top.sv
// Self-checking bench for jtag_tap_top: expected TDO bits are queued as stimulus is driven
// and compared on each falling TCK edge where the DUT enables TDO.
module tb_jtag_tap_top;
    localparam logic [31:0] IdcodeValue = 32'h149511C3;
`ifdef TAP_IDCODE_EN
    localparam bit IdcodeEn = 1'b1;
`else
    localparam bit IdcodeEn = 1'b0;
`endif

    logic tck_pad_i      = 1'b0;
    logic trst_pad_i     = 1'b0;
    logic tms_pad_i      = 1'b1;
    logic tdi_pad_i      = 1'b0;
    logic bs_chain_tdi_i = 1'b0;
    logic debug_tdi_i    = 1'b0;
    logic mbist_tdi_i    = 1'b0;
    logic tdo_pad_o, tdo_padoe_o, tdo_o;
    logic shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o;
    logic extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o;

    jtag_tap_top #(.IDCODE_VALUE(IdcodeValue)) dut (
        .tck_pad_i              (tck_pad_i),
        .trst_pad_i             (trst_pad_i),
        .tms_pad_i              (tms_pad_i),
        .tdi_pad_i              (tdi_pad_i),
        .tdo_pad_o              (tdo_pad_o),
        .tdo_padoe_o            (tdo_padoe_o),
        .tdo_o                  (tdo_o),
        .shift_dr_o             (shift_dr_o),
        .pause_dr_o             (pause_dr_o),
        .update_dr_o            (update_dr_o),
        .capture_dr_o           (capture_dr_o),
        .extest_select_o        (extest_select_o),
        .sample_preload_select_o(sample_preload_select_o),
        .mbist_select_o         (mbist_select_o),
        .debug_select_o         (debug_select_o),
        .bs_chain_tdi_i         (bs_chain_tdi_i),
        .debug_tdi_i            (debug_tdi_i),
        .mbist_tdi_i            (mbist_tdi_i)
    );

    always #10 tck_pad_i = ~tck_pad_i;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every enabled TDO bit must match the oldest queued expectation.
    always @(negedge tck_pad_i) begin
        #2;
        if (tdo_padoe_o) begin
            check_eq("tdo_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("tdo_bit", 32'(tdo_pad_o), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input logic tms, input logic tdi);
        tms_pad_i = tms;
        tdi_pad_i = tdi;
        @(posedge tck_pad_i);
        @(negedge tck_pad_i);
        #1;
    endtask

    function automatic logic [3:0] sel_vec();
        return {extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o};
    endfunction

    // Starts in Capture-x, shifts n bits, then Exit1 -> Pause -> Exit2 -> Update -> Run-Test/Idle.
    task automatic shift_seq(input int n, input logic is_dr, input logic [31:0] tdi_v,
                             input logic [31:0] bs_v, input logic [31:0] dbg_v,
                             input logic [31:0] mb_v, input logic [31:0] exp_v);
        bs_chain_tdi_i = bs_v[0];
        debug_tdi_i    = dbg_v[0];
        mbist_tdi_i    = mb_v[0];
        exp_q.push_back(exp_v[0]);
        step(1'b0, 1'b0);
        check_eq("shift_dr", 32'(shift_dr_o), 32'(is_dr));
        for (int i = 0; i < n; i++) begin
            if (i < n - 1) begin
                bs_chain_tdi_i = bs_v[i+1];
                debug_tdi_i    = dbg_v[i+1];
                mbist_tdi_i    = mb_v[i+1];
                exp_q.push_back(exp_v[i+1]);
            end
            step(i == n - 1, tdi_v[i]);
        end
        step(1'b0, 1'b0);
        check_eq("pause_dr", 32'(pause_dr_o), 32'(is_dr));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("update_dr", 32'(update_dr_o), 32'(is_dr));
        step(1'b0, 1'b0);
    endtask

    task automatic to_capture_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("capture_dr", 32'(capture_dr_o), 32'd1);
    endtask

    task automatic to_capture_ir();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("capture_ir_not_dr", 32'(capture_dr_o), 32'd0);
    endtask

    // Captured 0101 always comes out first, whatever code is shifted in.
    task automatic load_ir(input logic [3:0] code, input logic [3:0] exp_sel);
        to_capture_ir();
        shift_seq(4, 1'b0, 32'(code), 32'd0, 32'd0, 32'd0, 32'h5);
        check_eq("ir_select", 32'(sel_vec()), 32'(exp_sel));
        check_eq("oe_idle", 32'(tdo_padoe_o), 32'd0);
    endtask

    task automatic read_dr(input int n, input logic [31:0] tdi_v, input logic [31:0] bs_v,
                           input logic [31:0] dbg_v, input logic [31:0] mb_v,
                           input logic [31:0] exp_v);
        to_capture_dr();
        shift_seq(n, 1'b1, tdi_v, bs_v, dbg_v, mb_v, exp_v);
    endtask

    function automatic logic [31:0] reset_read_exp(input logic [31:0] tdi_v);
        return IdcodeEn ? IdcodeValue : {tdi_v[30:0], 1'b0};
    endfunction

    task automatic resync_after_reset();
        tms_pad_i = 1'b1;
        @(negedge tck_pad_i);
        #1;
    endtask

    initial begin
        #3;
        trst_pad_i = 1'b1;
        #1;
        check_eq("rst_oe", 32'(tdo_padoe_o), 32'd0);
        check_eq("rst_tdo", 32'(tdo_pad_o), 32'd0);
        check_eq("rst_selects", 32'(sel_vec()), 32'd0);
        check_eq("rst_strobes", 32'({shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o}), 32'd0);
        #9;
        trst_pad_i = 1'b0;
        resync_after_reset();

        tdi_pad_i = 1'b1;
        #1 check_eq("tdo_fwd_1", 32'(tdo_o), 32'd1);
        tdi_pad_i = 1'b0;
        #1 check_eq("tdo_fwd_0", 32'(tdo_o), 32'd0);

        // FSM walk: 0,1,1,0,0 into Shift-IR, then five 1s back to Test-Logic-Reset.
        step(1'b0, 1'b0);
        to_capture_ir();
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0);
        check_eq("walk_shift_ir_oe", 32'(tdo_padoe_o), 32'd1);
        check_eq("walk_shift_ir_not_dr", 32'(shift_dr_o), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_eq("walk_tlr_oe", 32'(tdo_padoe_o), 32'd0);
        step(1'b0, 1'b0);

        read_dr(32, 32'hA5A5_0F0F, 32'd0, 32'd0, 32'd0, reset_read_exp(32'hA5A5_0F0F));

        load_ir(4'b0001, 4'b0100);
        read_dr(4, 32'h0, 32'h5, 32'hA, 32'h3, 32'h5);
        load_ir(4'b1000, 4'b0001);
        read_dr(4, 32'h0, 32'h5, 32'hA, 32'h3, 32'hA);
        load_ir(4'b1001, 4'b0010);
        read_dr(4, 32'h0, 32'h5, 32'hA, 32'h3, 32'h3);
        load_ir(4'b0000, 4'b1000);
        read_dr(4, 32'h0, 32'h6, 32'hA, 32'h3, 32'h6);
        load_ir(4'b1111, 4'b0000);
        read_dr(8, 32'hFF, 32'h0, 32'h0, 32'h0, 32'hFE);
        load_ir(4'b0111, 4'b0000);
        read_dr(8, 32'hB6, 32'hFF, 32'hFF, 32'hFF, 32'h6C);
        load_ir(4'b0010, 4'b0000);
        read_dr(32, 32'h1234_5678, 32'd0, 32'd0, 32'd0, reset_read_exp(32'h1234_5678));

        // Test-Logic-Reset forces the reset instruction.
        load_ir(4'b0001, 4'b0100);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_eq("tlr_selects", 32'(sel_vec()), 32'd0);
        step(1'b0, 1'b0);
        read_dr(32, 32'hFFFF_0000, 32'd0, 32'd0, 32'd0, reset_read_exp(32'hFFFF_0000));

        // Asynchronous reset in the middle of a DR shift.
        load_ir(4'b0001, 4'b0100);
        to_capture_dr();
        bs_chain_tdi_i = 1'b1;
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0);
        bs_chain_tdi_i = 1'b0;
        exp_q.push_back(1'b0);
        step(1'b0, 1'b1);
        check_eq("mid_shift_dr", 32'(shift_dr_o), 32'd1);
        #4;
        trst_pad_i = 1'b1;
        #1;
        check_eq("mid_rst_shift_dr", 32'(shift_dr_o), 32'd0);
        check_eq("mid_rst_oe", 32'(tdo_padoe_o), 32'd0);
        check_eq("mid_rst_selects", 32'(sel_vec()), 32'd0);
        #9;
        trst_pad_i = 1'b0;
        resync_after_reset();
        step(1'b0, 1'b0);
        read_dr(32, 32'h0F0F_A5A5, 32'd0, 32'd0, 32'd0, reset_read_exp(32'h0F0F_A5A5));

        check_eq("tdo_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
